tone_sequencer: RTL and testbench

Parametrised audio tone generator that plays a programmable sequence of up to NUM_NOTES notes on the PmodAMP2, one square-wave frequency and one millisecond duration per note. It replaces the fixed 440 Hz buzzer. It has a start/stop/busy/done control handshake, rest notes, an end-of-sequence marker, and optional looping. It sits between the game/alarm control logic and the PmodAMP2 pins (JA1–JA3).

---
 rtl/tone_seq_pkg.sv | 11 +
 rtl/tone_sequencer_tone_divider.sv | 23 ++
 rtl/tone_sequencer.sv | 111 +++++++++++
 tb/tb_tone_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared FSM states, ms tick divider and 100 MHz note half-periods for tone_sequencer
package tone_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;
  localparam int G4_HALF = 127551;
  localparam int A4_HALF = 113636;
  localparam int C5_HALF = 95556;
  localparam int E5_HALF = 75843;
  function automatic int ms_tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction
endpackage

// File: rtl/tone_sequencer_tone_divider.sv
// tone_divider: half-period counter plus toggle flop; half==0 holds the wave low
module tone_divider #(
  parameter int HALF_W = 18
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  input logic [HALF_W-1:0] half,
  output logic wave
);
  logic [HALF_W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == half - 1'b1;
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      wave <= 1'b0;
    end else if (en && half != '0) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      wave <= wrap ? ~wave : wave;
    end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: programmable note-sequence square-wave player for the PmodAMP2.
// Define TONE_SEQ_VOLUME_EN to add a 3-bit PWM volume input.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int NUM_NOTES = 8,
  parameter int HALF_W = 18,
  parameter int DUR_W = 10,
  parameter bit GAIN_HI = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic stop,
  input logic loop_en,
`ifdef TONE_SEQ_VOLUME_EN
  input logic [2:0] volume,
`endif
  input logic wr_en,
  input logic [$clog2(NUM_NOTES)-1:0] wr_addr,
  input logic [HALF_W-1:0] wr_half,
  input logic [DUR_W-1:0] wr_dur,
  output logic audio_out,
  output logic amp_gain,
  output logic amp_shdn,
  output logic busy,
  output logic done,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx
);
  localparam int AW = $clog2(NUM_NOTES);
  localparam int DIV = ms_tick_div(CLK_HZ);
  localparam int PW = $clog2(DIV + 1);
  localparam logic [AW-1:0] LAST = AW'(NUM_NOTES - 1);
  state_t state;
  logic [HALF_W-1:0] half_mem [NUM_NOTES];
  logic [DUR_W-1:0] dur_mem [NUM_NOTES];
  logic [HALF_W-1:0] cur_half;
  logic [DUR_W-1:0] cur_dur, ms;
  logic [PW-1:0] pre;
  logic ms_wrap, note_end, tone_clr, wave;
  assign ms_wrap = pre == PW'(DIV - 1);
  assign note_end = state == PLAY && ms_wrap && ms == cur_dur - 1'b1;
  // clearing on the exit edge keeps audio low through the following LOAD/IDLE cycle
  assign tone_clr = stop || state != PLAY || note_end;
  assign amp_gain = GAIN_HI;
  assign amp_shdn = busy;
  always_ff @(posedge clk)
    if (wr_en) begin
      half_mem[wr_addr] <= wr_half;
      dur_mem[wr_addr] <= wr_dur;
    end
  always_ff @(posedge clk)
    if (rst || stop) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      note_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
          note_idx <= '0;
        end
        LOAD: if (dur_mem[note_idx] != '0) begin
          state <= PLAY;
          cur_half <= half_mem[note_idx];
          cur_dur <= dur_mem[note_idx];
          pre <= '0;
          ms <= '0;
        end else if (loop_en && note_idx != '0) begin
          note_idx <= '0;
        end else begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        PLAY: begin
          pre <= ms_wrap ? '0 : pre + 1'b1;
          ms <= ms_wrap ? ms + 1'b1 : ms;
          if (note_end && (note_idx != LAST || loop_en)) begin
            state <= LOAD;
            note_idx <= note_idx != LAST ? note_idx + 1'b1 : '0;
          end else if (note_end) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  tone_divider #(.HALF_W(HALF_W)) u_div (
    .clk(clk),
    .rst(rst),
    .clr(tone_clr),
    .en(state == PLAY),
    .half(cur_half),
    .wave(wave)
  );
`ifdef TONE_SEQ_VOLUME_EN
  logic [2:0] frame;
  always_ff @(posedge clk)
    frame <= (rst || tone_clr) ? 3'd0 : frame + 3'd1;
  assign audio_out = wave && frame <= volume;
`else
  assign audio_out = wave;
`endif
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: note-timeline model plus directed literal checks for tone_sequencer at 1 ms = 10 clocks
module tb_tone_sequencer;
  localparam int N = 8, HW = 18, DW = 10, AW = 3, DIV = 10;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [HW-1:0] wr_half = '0;
  logic [DW-1:0] wr_dur = '0;
  logic audio_out, amp_gain, amp_shdn, busy, done;
  logic [AW-1:0] note_idx;
  int errors = 0, checks = 0;
  int tbl_half [N], tbl_dur [N];
  typedef struct {logic audio; logic busy; logic done; int idx;} exp_t;
  exp_t q[$];
  exp_t e;
  logic s_audio [200], s_busy [200], s_done [200];
  int s_idx [200];
  tone_sequencer #(.CLK_HZ(10_000), .NUM_NOTES(N), .HALF_W(HW), .DUR_W(DW), .GAIN_HI(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half), .wr_dur(wr_dur),
    .audio_out(audio_out), .amp_gain(amp_gain), .amp_shdn(amp_shdn),
    .busy(busy), .done(done), .note_idx(note_idx)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // expand the whole playback into one expected entry per clock after start is taken
  function automatic void build(input bit lp);
    int idx = 0;
    q.delete();
    while (q.size() < 3000) begin
      q.push_back('{1'b0, 1'b1, 1'b0, idx});
      if (tbl_dur[idx] == 0) begin
        if (idx == 0 || !lp) begin
          q.push_back('{1'b0, 1'b0, 1'b1, -1});
          return;
        end
        idx = 0;
      end else begin
        for (int t = 0; t < tbl_dur[idx] * DIV; t++)
          q.push_back('{tbl_half[idx] != 0 && (t / tbl_half[idx]) % 2 == 1, 1'b1, 1'b0, idx});
        if (idx == N - 1) begin
          if (!lp) begin
            q.push_back('{1'b0, 1'b0, 1'b1, -1});
            return;
          end
          idx = 0;
        end else idx++;
      end
    end
  endfunction
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) e = q.pop_front();
    else e = '{1'b0, 1'b0, 1'b0, -1};
    check("audio_out", int'(audio_out), int'(e.audio));
    check("busy", int'(busy), int'(e.busy));
    check("done", int'(done), int'(e.done));
    check("amp_shdn", int'(amp_shdn), int'(e.busy));
    check("amp_gain", int'(amp_gain), 1);
    if (e.idx >= 0) check("note_idx", int'(note_idx), e.idx);
  end
  task automatic wr(input int a, input int h, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_half = HW'(h);
    wr_dur = DW'(d);
    tbl_half[a] = h;
    tbl_dur[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic go(input bit lp, input int n, input int poke);
    loop_en = lp;
    start = 1'b1;
    build(lp);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = i == poke;
      s_audio[i] = audio_out;
      s_busy[i] = busy;
      s_done[i] = done;
      s_idx[i] = int'(note_idx);
    end
    start = 1'b0;
  endtask
  function automatic int cnt_busy(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(s_busy[i]);
    return c;
  endfunction
  function automatic int cnt_audio(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(s_audio[i]);
    return c;
  endfunction
  function automatic int cnt_done(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(s_done[i]);
    return c;
  endfunction
  task automatic idle_outputs(input string tag);
    check({tag, "_audio"}, int'(audio_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_shdn"}, int'(amp_shdn), 0);
    check({tag, "_idx"}, int'(note_idx), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    rst = 1'b0;
    for (int a = 0; a < N; a++) wr(a, 0, 0);
    // single 4-clock-period note of 3 ms, then the marker LOAD and DONE
    wr(0, 2, 3);
    go(1'b0, 40, 0);
    check("t1_busy_len", cnt_busy(1, 40), 32);
    check("t1_done_cnt", cnt_done(1, 40), 1);
    check("t1_done_at", int'(s_done[33]), 1);
    check("t1_aud_i2", int'(s_audio[2]), 0);
    check("t1_aud_i4", int'(s_audio[4]), 1);
    check("t1_aud_i6", int'(s_audio[6]), 0);
    repeat (3) @(negedge clk);
    // tone then rest then marker
    wr(0, 3, 1);
    wr(1, 0, 2);
    go(1'b0, 40, 0);
    check("t2_busy_len", cnt_busy(1, 40), 33);
    check("t2_done_at", int'(s_done[34]), 1);
    check("t2_tone_highs", cnt_audio(2, 11), 4);
    check("t2_rise_i5", int'(s_audio[5]), 1);
    check("t2_rest_highs", cnt_audio(12, 33), 0);
    repeat (3) @(negedge clk);
    // same table looping, then aborted
    go(1'b1, 120, 0);
    check("t3_busy_len", cnt_busy(1, 120), 120);
    check("t3_no_done", cnt_done(1, 120), 0);
    check("t3_idx_i12", s_idx[12], 1);
    check("t3_idx_i34", s_idx[34], 0);
    check("t3_idx_i45", s_idx[45], 1);
    stop = 1'b1;
    q.delete();
    @(negedge clk);
    stop = 1'b0;
    idle_outputs("t3_stop");
    repeat (3) @(negedge clk);
    // empty sequence
    wr(0, 5, 0);
    go(1'b0, 6, 0);
    check("t4_busy_i1", int'(s_busy[1]), 1);
    check("t4_done_i2", int'(s_done[2]), 1);
    check("t4_busy_i2", int'(s_busy[2]), 0);
    check("t4_no_audio", cnt_audio(1, 6), 0);
    // full table of 1 ms notes, with a stray start mid-play
    for (int a = 0; a < N; a++) wr(a, 1, 1);
    go(1'b0, 95, 20);
    check("t5_busy_len", cnt_busy(1, 95), 88);
    check("t5_done_at", int'(s_done[89]), 1);
    check("t5_done_cnt", cnt_done(1, 95), 1);
    check("t5_idx_last", s_idx[78], 7);
    check("t5_idx_i12", s_idx[12], 1);
    repeat (2) @(negedge clk);
    // reset in the middle of note 2
    go(1'b0, 30, 0);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    idle_outputs("t5_rst");
    rst = 1'b0;
    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    idle_outputs("startstop");
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
